wash_sequencer: RTL and testbench
=================================

Name: wash_sequencer

Overview:
- Program sequencer for the washing machine, directly downstream of the power/start-pause controller.
- Consumes the controller's power and run/pause levels plus the mode and clothes-add pulses. Steps through fill/agitate/drain/spin phases for the selected program.
- Drives the wash/rinse/dry/inwater/outwater/buzzer lights and a remaining-time count. The controller reads that count to detect completion and auto power-off.

Parameters:
- FILL_T, 2, seconds of water inlet per wash/rinse stage
- WASH_T, 9, seconds of agitation in the wash stage
- RINSE_T, 6, seconds of agitation in the rinse stage
- DRAIN_T, 2, seconds of drain per wash/rinse stage
- SPIN_T, 3, seconds of spin-dry
- ADD_T, 4, seconds of hold when clothes are added
- BUZZ_T, 10, seconds buzzer stays on after completion
- Constraint: sum of all phase times ≤ 127.

Ports:
- clk_1HZ  in  1  1 Hz system tick
- reset  in  1  asynchronous, active-high
- power_on  in  1  power light level from controller
- run  in  1  start light level: 1 = running, 0 = idle or paused
- mode_sel  in  1  one-clock pulse, already synchronized to clk_1HZ; advances program
- clothes_add  in  1  one-clock pulse, already synchronized to clk_1HZ
- mode  out  2  selected program: 0 full, 1 wash-only, 2 rinse+spin, 3 spin-only
- wash_light  out  1  wash stage active/selected
- dwash_light  out  1  rinse stage active/selected
- dry_light  out  1  spin stage active/selected
- inwater_light  out  1  inlet valve on
- outwater_light  out  1  drain pump on
- buzzer_light  out  1  completion buzzer
- total_time  out  7  remaining program seconds
- phase_time  out  7  remaining seconds of current phase
- done  out  1  program complete

Behaviour:
- Reset (async): all outputs 0, mode=0, state IDLE. total_time is updated to 26 (full-program preview) at the first clock after reset deassert.
- Priority per clock: power_on=0 > run=0 (pause) > clothes_add > mode_sel.
- power_on=0 at a clock edge: IDLE, mode=0, all counters, lights and done cleared. This holds mid-run and in DONE.
- States: IDLE, FILL, AGITATE, DRAIN, SPIN, HOLD, DONE. A stage bit (WASH/RINSE) qualifies FILL/AGITATE/DRAIN.
- IDLE:
  - mode_sel increments mode mod 4.
  - Stage lights preview the stages in the selected mode; water lights 0.
  - total_time = program total: mode0 = 26, mode1 = 13, mode2 = 13, mode3 = 3 at defaults.
  - run=1 with power_on=1 enters the first phase of the mode, loads phase_time with that phase's duration, and keeps total_time.
- Phase order:
  - WASH stage: FILL→AGITATE(WASH_T)→DRAIN.
  - RINSE stage: FILL→AGITATE(RINSE_T)→DRAIN.
  - Then SPIN.
  - Stages not in the mode are skipped.
- Each running clock:
  - total_time decrements by 1.
  - If phase_time>1, phase_time decrements. Otherwise the next phase is entered with its duration loaded.
  - After the last phase, enter DONE with total_time=0, phase_time=0.
  - Each phase therefore lasts exactly its duration in clocks; a program lasts exactly its total.
- Lights while running:
  - Only the current stage light is on.
  - inwater=1 in FILL. outwater=1 in DRAIN and SPIN.
- Pause (run=0 outside IDLE/DONE): all counters frozen; water lights 0; stage light held. run=1 resumes the same phase with no lost seconds.
- Clothes add:
  - clothes_add while running in WASH-stage FILL or AGITATE → HOLD for ADD_T running clocks.
  - During HOLD: counters frozen, water lights 0, wash_light on.
  - After HOLD, return to the saved phase with its phase_time unchanged.
  - Ignored in any other state. A second pulse during HOLD is ignored.
- mode_sel outside IDLE: ignored.
- DONE:
  - done=1 and all stage/water lights 0.
  - buzzer_light=1 for BUZZ_T clocks, then 0; it runs regardless of run.
  - done held until power_on=0.
- Widths: counters are 7-bit unsigned. total_time never wraps below 0.

Decomposition:
- Package wash_pkg: state enum, stage enum, mode encoding constants, phase-duration constants derived from parameters, and a function returning stage mask and total time per mode.
- One sub-module, phase_timer: loadable 7-bit down counter with enable and a last-tick flag. Instanced for phase_time and for the HOLD/buzzer counter.

Test Plan:
- Reset → power_on=1 → run=1 in mode0 → sequence FILL(2) AGITATE(9) DRAIN(2) FILL(2) AGITATE(6) DRAIN(2) SPIN(3) with correct lights; total_time 26→0 over 26 clocks; done=1; buzzer high 10 clocks then low.
- mode_sel ×3 in IDLE → mode=3, total_time=3, only dry_light on; run → SPIN 3 clocks with outwater=1 → DONE.
- Mode1 running; run=0 at AGITATE with phase_time=5 for 4 clocks → counters frozen, inwater/outwater 0; run=1 → phase_time resumes 5→4; total 13 clocks of running time.
- clothes_add in WASH AGITATE with phase_time=7 → HOLD for 4 clocks, total_time frozen → back to AGITATE with phase_time=7. clothes_add in RINSE → ignored.
- power_on drops mid-DRAIN → next clock all outputs 0, mode=0, IDLE. Async reset mid-SPIN → immediate clear.
- mode_sel pulse while running → mode unchanged. Same clock run=0 and clothes_add → pause only, no HOLD.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types, phase durations and per-program helpers for the wash sequencer.
package wash_pkg;

  localparam int unsigned FILL_T  = 2;
  localparam int unsigned WASH_T  = 9;
  localparam int unsigned RINSE_T = 6;
  localparam int unsigned DRAIN_T = 2;
  localparam int unsigned SPIN_T  = 3;
  localparam int unsigned ADD_T   = 4;
  localparam int unsigned BUZZ_T  = 10;

  localparam int CNT_W = 7;

  localparam logic [CNT_W-1:0] FILL_D        = CNT_W'(FILL_T);
  localparam logic [CNT_W-1:0] WASH_D        = CNT_W'(WASH_T);
  localparam logic [CNT_W-1:0] RINSE_D       = CNT_W'(RINSE_T);
  localparam logic [CNT_W-1:0] DRAIN_D       = CNT_W'(DRAIN_T);
  localparam logic [CNT_W-1:0] SPIN_D        = CNT_W'(SPIN_T);
  localparam logic [CNT_W-1:0] ADD_D         = CNT_W'(ADD_T);
  localparam logic [CNT_W-1:0] BUZZ_D        = CNT_W'(BUZZ_T);
  localparam logic [CNT_W-1:0] WASH_STAGE_D  = CNT_W'(FILL_T + WASH_T + DRAIN_T);
  localparam logic [CNT_W-1:0] RINSE_STAGE_D = CNT_W'(FILL_T + RINSE_T + DRAIN_T);

  localparam logic [1:0] MODE_FULL       = 2'd0;
  localparam logic [1:0] MODE_WASH       = 2'd1;
  localparam logic [1:0] MODE_RINSE_SPIN = 2'd2;
  localparam logic [1:0] MODE_SPIN       = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_AGITATE, ST_DRAIN, ST_SPIN, ST_HOLD, ST_DONE
  } state_t;

  typedef enum logic {STG_WASH, STG_RINSE} stage_t;

  typedef struct packed {
    logic wash;
    logic rinse;
    logic spin;
  } stage_mask_t;

  typedef struct packed {
    stage_mask_t      mask;
    logic [CNT_W-1:0] total;
  } mode_info_t;

  typedef struct packed {
    logic wash;
    logic dwash;
    logic dry;
    logic inwater;
    logic outwater;
  } lights_t;

  function automatic mode_info_t mode_info(input logic [1:0] mode);
    mode_info_t mi;
    mi = '0;
    case (mode)
      MODE_FULL:       mi.mask = 3'b111;
      MODE_WASH:       mi.mask = 3'b100;
      MODE_RINSE_SPIN: mi.mask = 3'b011;
      default:         mi.mask = 3'b001;
    endcase
    mi.total = (mi.mask.wash  ? WASH_STAGE_D  : '0)
             + (mi.mask.rinse ? RINSE_STAGE_D : '0)
             + (mi.mask.spin  ? SPIN_D        : '0);
    return mi;
  endfunction

  function automatic logic [CNT_W-1:0] phase_dur(input state_t st, input stage_t stg);
    case (st)
      ST_FILL:    return FILL_D;
      ST_AGITATE: return (stg == STG_WASH) ? WASH_D : RINSE_D;
      ST_DRAIN:   return DRAIN_D;
      ST_SPIN:    return SPIN_D;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter with enable; stops at zero and flags the final tick.
module phase_timer
  import wash_pkg::*;
(
  input  logic             clk_1HZ,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_1HZ or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign last_o  = (count_q <= CNT_W'(1));

endmodule

// File: rtl/wash_sequencer.sv
// Washing-program sequencer: IDLE, FILL/AGITATE/DRAIN (per stage), SPIN, HOLD (clothes add,
// resumes saved phase), DONE (buzzer then wait for power-off).
module wash_sequencer
  import wash_pkg::*;
(
  input  logic             clk_1HZ,
  input  logic             reset,
  input  logic             power_on,
  input  logic             run,
  input  logic             mode_sel,
  input  logic             clothes_add,
  output logic [1:0]       mode,
  output logic             wash_light,
  output logic             dwash_light,
  output logic             dry_light,
  output logic             inwater_light,
  output logic             outwater_light,
  output logic             buzzer_light,
  output logic [CNT_W-1:0] total_time,
  output logic [CNT_W-1:0] phase_time,
  output logic             done
);

  state_t           state_q, state_d, ret_q, ret_d, adv_state, start_state;
  stage_t           stage_q, stage_d, adv_stage, start_stage;
  logic [1:0]       mode_q, mode_d, idle_mode;
  logic [CNT_W-1:0] total_q, total_d;
  lights_t          lights_q, lights_d;
  mode_info_t       cur_info, idle_info;
  logic             ph_load, ph_en, ph_last, ax_load, ax_en, ax_last, can_hold;
  logic [CNT_W-1:0] ph_val, ph_cnt, ax_val, ax_cnt;

  assign idle_mode = (mode_sel && !run) ? mode_q + 2'd1 : mode_q;
  assign cur_info  = mode_info(mode_q);
  assign idle_info = mode_info(idle_mode);
  assign can_hold  = (stage_q == STG_WASH) && ((state_q == ST_FILL) || (state_q == ST_AGITATE));

  always_comb begin
    start_state = ST_FILL;
    start_stage = STG_WASH;
    if (!cur_info.mask.wash) begin
      if (cur_info.mask.rinse) start_stage = STG_RINSE;
      else                     start_state = ST_SPIN;
    end
  end

  always_comb begin
    adv_state = ST_DONE;
    adv_stage = stage_q;
    case (state_q)
      ST_FILL:    adv_state = ST_AGITATE;
      ST_AGITATE: adv_state = ST_DRAIN;
      ST_DRAIN: begin
        if ((stage_q == STG_WASH) && cur_info.mask.rinse) begin
          adv_state = ST_FILL;
          adv_stage = STG_RINSE;
        end else if (cur_info.mask.spin) begin
          adv_state = ST_SPIN;
        end
      end
      default:    adv_state = ST_DONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    ret_d   = ret_q;
    mode_d  = mode_q;
    total_d = total_q;
    ph_load = 1'b0;
    ph_val  = '0;
    ph_en   = 1'b0;
    ax_load = 1'b0;
    ax_val  = '0;
    ax_en   = 1'b0;
    if (!power_on) begin
      state_d = ST_IDLE;
      stage_d = STG_WASH;
      mode_d  = MODE_FULL;
      total_d = '0;
      ph_load = 1'b1;
      ax_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mode_d  = idle_mode;
          total_d = idle_info.total;
          if (run) begin
            state_d = start_state;
            stage_d = start_stage;
            ph_load = 1'b1;
            ph_val  = phase_dur(start_state, start_stage);
          end
        end
        ST_FILL, ST_AGITATE, ST_DRAIN, ST_SPIN: begin
          if (run) begin
            if (clothes_add && can_hold) begin
              state_d = ST_HOLD;
              ret_d   = state_q;
              ax_load = 1'b1;
              ax_val  = ADD_D;
            end else begin
              total_d = (total_q != '0) ? total_q - CNT_W'(1) : '0;
              if (!ph_last) begin
                ph_en = 1'b1;
              end else begin
                state_d = adv_state;
                stage_d = adv_stage;
                ph_load = 1'b1;
                ph_val  = phase_dur(adv_state, adv_stage);
                if (adv_state == ST_DONE) begin
                  total_d = '0;
                  ax_load = 1'b1;
                  ax_val  = BUZZ_D;
                end
              end
            end
          end
        end
        ST_HOLD: begin
          if (run) begin
            if (!ax_last) begin
              ax_en = 1'b1;
            end else begin
              state_d = ret_q;
              ax_load = 1'b1;
            end
          end
        end
        ST_DONE: ax_en = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Water lights follow run directly so a paused phase never leaves a valve or pump on.
  always_comb begin
    lights_d = '0;
    if (power_on) begin
      case (state_d)
        ST_IDLE: begin
          lights_d.wash  = idle_info.mask.wash;
          lights_d.dwash = idle_info.mask.rinse;
          lights_d.dry   = idle_info.mask.spin;
        end
        ST_FILL, ST_AGITATE, ST_DRAIN: begin
          lights_d.wash     = (stage_d == STG_WASH);
          lights_d.dwash    = (stage_d == STG_RINSE);
          lights_d.inwater  = run && (state_d == ST_FILL);
          lights_d.outwater = run && (state_d == ST_DRAIN);
        end
        ST_SPIN: begin
          lights_d.dry      = 1'b1;
          lights_d.outwater = run;
        end
        ST_HOLD: lights_d.wash = 1'b1;
        default: lights_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_1HZ or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      stage_q  <= STG_WASH;
      ret_q    <= ST_IDLE;
      mode_q   <= MODE_FULL;
      total_q  <= '0;
      lights_q <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      ret_q    <= ret_d;
      mode_q   <= mode_d;
      total_q  <= total_d;
      lights_q <= lights_d;
    end
  end

  phase_timer u_phase (
    .clk_1HZ    (clk_1HZ),
    .reset      (reset),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .en_i       (ph_en),
    .count_o    (ph_cnt),
    .last_o     (ph_last)
  );

  // Shared between the clothes-add hold and the completion buzzer; never both active.
  phase_timer u_aux (
    .clk_1HZ    (clk_1HZ),
    .reset      (reset),
    .load_i     (ax_load),
    .load_val_i (ax_val),
    .en_i       (ax_en),
    .count_o    (ax_cnt),
    .last_o     (ax_last)
  );

  assign mode           = mode_q;
  assign wash_light     = lights_q.wash;
  assign dwash_light    = lights_q.dwash;
  assign dry_light      = lights_q.dry;
  assign inwater_light  = lights_q.inwater;
  assign outwater_light = lights_q.outwater;
  assign buzzer_light   = (state_q == ST_DONE) && (ax_cnt != '0);
  assign total_time     = total_q;
  assign phase_time     = ph_cnt;
  assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench: a phase-list model predicts every output each clock and queues it for comparison.
module tb_wash_sequencer;

  logic       clk_1HZ = 1'b0;
  logic       reset, power_on, run, mode_sel, clothes_add;
  logic [1:0] mode;
  logic       wash_light, dwash_light, dry_light, inwater_light, outwater_light, buzzer_light;
  logic [6:0] total_time, phase_time;
  logic       done;

  wash_sequencer dut (
    .clk_1HZ        (clk_1HZ),
    .reset          (reset),
    .power_on       (power_on),
    .run            (run),
    .mode_sel       (mode_sel),
    .clothes_add    (clothes_add),
    .mode           (mode),
    .wash_light     (wash_light),
    .dwash_light    (dwash_light),
    .dry_light      (dry_light),
    .inwater_light  (inwater_light),
    .outwater_light (outwater_light),
    .buzzer_light   (buzzer_light),
    .total_time     (total_time),
    .phase_time     (phase_time),
    .done           (done)
  );

  always #5 clk_1HZ = ~clk_1HZ;

  typedef struct packed {
    logic [6:0] total;
    logic [6:0] phase;
    logic [1:0] mode;
    logic [5:0] lights;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // model: state 0 idle, 1 running/hold, 2 done; phase kinds 1 fill, 2 agitate, 3 drain, 4 spin
  int m_state, m_mode, m_total, m_phase, m_idx, m_hold, m_buzz;
  bit m_pwr, m_run;
  int p_kind[$];
  int p_stg[$];
  int p_dur[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int mask_of(input int md);
    case (md)
      0:       return 7;
      1:       return 4;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int total_of(input int md);
    int mk;
    mk = mask_of(md);
    return ((mk & 4) != 0 ? 13 : 0) + ((mk & 2) != 0 ? 10 : 0) + ((mk & 1) != 0 ? 3 : 0);
  endfunction

  task automatic build_list(input int md);
    int mk;
    mk = mask_of(md);
    p_kind.delete(); p_stg.delete(); p_dur.delete();
    if ((mk & 4) != 0) begin
      p_kind.push_back(1); p_stg.push_back(0); p_dur.push_back(2);
      p_kind.push_back(2); p_stg.push_back(0); p_dur.push_back(9);
      p_kind.push_back(3); p_stg.push_back(0); p_dur.push_back(2);
    end
    if ((mk & 2) != 0) begin
      p_kind.push_back(1); p_stg.push_back(1); p_dur.push_back(2);
      p_kind.push_back(2); p_stg.push_back(1); p_dur.push_back(6);
      p_kind.push_back(3); p_stg.push_back(1); p_dur.push_back(2);
    end
    if ((mk & 1) != 0) begin
      p_kind.push_back(4); p_stg.push_back(2); p_dur.push_back(3);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_total = 0; m_phase = 0; m_idx = 0;
    m_hold = 0; m_buzz = 0; m_pwr = 0; m_run = 0;
  endtask

  task automatic model_step();
    if (!power_on) begin
      model_reset();
    end else begin
      m_pwr = 1;
      case (m_state)
        0: begin
          if (run) begin
            build_list(m_mode);
            m_idx = 0; m_phase = p_dur[0]; m_state = 1;
          end else if (mode_sel) begin
            m_mode = (m_mode + 1) % 4;
          end
          m_total = total_of(m_mode);
        end
        1: begin
          if (run) begin
            if (m_hold > 0) begin
              m_hold = m_hold - 1;
            end else if (clothes_add && p_stg[m_idx] == 0 && (p_kind[m_idx] == 1 || p_kind[m_idx] == 2)) begin
              m_hold = 4;
            end else begin
              if (m_total > 0) m_total--;
              if (m_phase > 1) m_phase--;
              else begin
                m_idx++;
                if (m_idx >= p_kind.size()) begin
                  m_state = 2; m_total = 0; m_phase = 0; m_buzz = 10;
                end else begin
                  m_phase = p_dur[m_idx];
                end
              end
            end
          end
        end
        default: if (m_buzz > 0) m_buzz--;
      endcase
    end
    m_run = run;
  endtask

  function automatic exp_t expected();
    exp_t e;
    int   mk;
    e = '0;
    e.total = 7'(m_total);
    e.phase = 7'(m_phase);
    e.mode  = 2'(m_mode);
    if (m_pwr) begin
      if (m_state == 0) begin
        mk = mask_of(m_mode);
        e.lights[5] = (mk & 4) != 0;
        e.lights[4] = (mk & 2) != 0;
        e.lights[3] = (mk & 1) != 0;
      end else if (m_state == 1) begin
        if (m_hold > 0) begin
          e.lights[5] = 1'b1;
        end else begin
          e.lights[5 - p_stg[m_idx]] = 1'b1;
          e.lights[2] = m_run && p_kind[m_idx] == 1;
          e.lights[1] = m_run && (p_kind[m_idx] == 3 || p_kind[m_idx] == 4);
        end
      end else begin
        e.done      = 1'b1;
        e.lights[0] = m_buzz > 0;
      end
    end
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    e = exp_q.pop_front();
    check_eq("total_time", total_time, e.total);
    check_eq("phase_time", phase_time, e.phase);
    check_eq("mode", mode, e.mode);
    check_eq("lights", {wash_light, dwash_light, dry_light, inwater_light, outwater_light, buzzer_light}, e.lights);
    check_eq("done", done, e.done);
  endtask

  task automatic cycle(input bit pwr, input bit r, input bit ms, input bit ca);
    power_on = pwr; run = r; mode_sel = ms; clothes_add = ca;
    model_step();
    exp_q.push_back(expected());
    @(posedge clk_1HZ);
    #1;
    check_out();
    mode_sel = 1'b0; clothes_add = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; power_on = 1'b1; run = 1'b0; mode_sel = 1'b0; clothes_add = 1'b0;
    model_reset();
    #12;
    reset = 1'b0;
    #1;
    exp_q.push_back(expected());
    check_out();

    // full program with a stray mode_sel mid-run, then buzzer with run toggling
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 26; i++) cycle(1, 1, i == 5, 0);
    for (int i = 0; i < 12; i++) cycle(1, i % 2 == 0, 0, 0);
    cycle(0, 0, 0, 0);

    // spin-only program
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0);
    check_eq("mode3_total", total_time, 3);
    check_eq("mode3_mode", mode, 3);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);

    // wash-only program with a pause at AGITATE phase_time=5
    cycle(1, 0, 1, 0);
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);
    check_eq("pause_entry_phase", phase_time, 5);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, i == 1);
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 0);
    check_eq("mode1_done", done, 1);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);

    // clothes add in wash AGITATE, ignored in rinse, power drop mid-DRAIN
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 1);
    cycle(1, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
    check_eq("hold_resume_phase", phase_time, 7);
    for (int i = 0; i < 11; i++) cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);

    // async reset during SPIN
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(expected());
    check_out();
    #2;
    reset = 1'b0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
